// File: rtl/store_buffer.sv
// store_buffer: in-order store write buffer between MEM-stage store issue and
// the data memory write port. It queues up to DEPTH stores, retires the oldest
// one per cycle unless DM stalls, and flags loads whose word matches any
// pending store so the hazard unit can hold the load until the buffer drains.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_size,
  input  logic [31:0] st_pc,
  output logic        st_ready,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  output logic        ld_conflict,
  input  logic        dm_stall,
  output logic        DMWr,
  output logic [31:0] DMAddr,
  output logic [31:0] DIN,
  output logic [2:0]  L_S_SL,
  output logic [31:0] PC,
  output logic        full,
  output logic        empty
);

  // Entry storage; contents are only meaningful inside the count window.
  logic [31:0] r_addr [DEPTH];
  logic [31:0] r_data [DEPTH];
  logic [2:0]  r_size [DEPTH];
  logic [31:0] r_pc   [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_conflict;
  logic [AW-1:0] w_idx;
  logic          w_unused_ld_low;

  // Word compare ignores the byte offset of the load address.
  assign w_unused_ld_low = ^ld_addr[1:0];

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  // A full buffer refuses a store even if the head retires on the same edge.
  assign w_push  = st_valid & ~w_full;
  assign w_pop   = ~w_empty & ~dm_stall;

  assign st_ready = ~w_full;
  assign full     = w_full;
  assign empty    = w_empty;

  // Head entry drives the DM write port directly; DM samples it on the pop edge.
  assign DMWr   = ~w_empty;
  assign DMAddr = r_addr[r_rd_ptr];
  assign DIN    = r_data[r_rd_ptr];
  assign L_S_SL = r_size[r_rd_ptr];
  assign PC     = r_pc[r_rd_ptr];

  // Pointer and occupancy update; Reset discards every in-flight entry.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Capture an accepted store into the tail slot.
  always_ff @(posedge clk) begin
    if (!Reset && w_push) begin
      r_addr[r_wr_ptr] <= st_addr;
      r_data[r_wr_ptr] <= st_data;
      r_size[r_wr_ptr] <= st_size;
      r_pc[r_wr_ptr]   <= st_pc;
    end
  end

  // Compare the load word against every live entry, walking from the head so
  // wrapped occupancy is handled; the head still counts while it is popping.
  always_comb begin
    w_conflict = 1'b0;
    w_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + AW'(i);
      if (((AW+1)'(i) < r_count) && (r_addr[w_idx][31:2] == ld_addr[31:2])) begin
        w_conflict = 1'b1;
      end else begin
        w_conflict = w_conflict;
      end
    end
  end

  assign ld_conflict = ld_req & w_conflict;

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scoreboard bench for store_buffer. Accepted stores are
// pushed to an expected queue; the head is compared every cycle and popped
// when DM takes it. Status flags and ld_conflict are predicted from the queue.
`timescale 1ns/1ps
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam logic [2:0] L_S_B = 3'd1;
  localparam logic [2:0] L_S_H = 3'd2;
  localparam logic [2:0] L_S_W = 3'd3;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
    logic [31:0] pc;
  } st_t;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = 32'd0;
  logic [31:0] st_data = 32'd0;
  logic [2:0]  st_size = 3'd0;
  logic [31:0] st_pc = 32'd0;
  logic        st_ready;
  logic        ld_req = 1'b0;
  logic [31:0] ld_addr = 32'd0;
  logic        ld_conflict;
  logic        dm_stall = 1'b0;
  logic        DMWr;
  logic [31:0] DMAddr;
  logic [31:0] DIN;
  logic [2:0]  L_S_SL;
  logic [31:0] PC;
  logic        full;
  logic        empty;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  mon_en = 1'b0;
  bit  m_last_push = 1'b0;
  int  n_dm_writes = 0;
  st_t exp_q[$];

  store_buffer #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk(clk), .Reset(Reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_size(st_size), .st_pc(st_pc), .st_ready(st_ready),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .dm_stall(dm_stall), .DMWr(DMWr), .DMAddr(DMAddr), .DIN(DIN),
    .L_S_SL(L_S_SL), .PC(PC), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Mid-cycle model: check flags/head/conflict, then apply next-edge effects.
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_conf;
      logic do_push;
      logic do_pop;
      exp_conf = 1'b0;
      foreach (exp_q[i]) begin
        if (exp_q[i].addr[31:2] == ld_addr[31:2]) exp_conf = 1'b1;
      end
      chk("empty", empty, exp_q.size() == 0);
      chk("full", full, exp_q.size() == DEPTH);
      chk("st_ready", st_ready, exp_q.size() < DEPTH);
      chk("DMWr", DMWr, exp_q.size() > 0);
      chk("ld_conflict", ld_conflict, ld_req && exp_conf);
      if (exp_q.size() > 0) begin
        chk("DMAddr", DMAddr, exp_q[0].addr);
        chk("DIN", DIN, exp_q[0].data);
        chk("L_S_SL", L_S_SL, exp_q[0].size);
        chk("PC", PC, exp_q[0].pc);
      end
      do_push = st_valid && (exp_q.size() < DEPTH) && !Reset;
      do_pop  = (exp_q.size() > 0) && !dm_stall && !Reset;
      m_last_push = do_push;
      if (DMWr && !dm_stall && !Reset) n_dm_writes++;
      if (Reset) begin
        exp_q.delete();
      end else begin
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back('{addr: st_addr, data: st_data, size: st_size, pc: st_pc});
      end
    end
  end

  // One cycle: let the monitor evaluate, then cross the edge.
  task automatic step();
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] s, input logic [31:0] p);
    int budget;
    st_valid = 1'b1; st_addr = a; st_data = d; st_size = s; st_pc = p;
    budget = 40;
    do begin
      step();
      budget--;
    end while (!m_last_push && budget > 0);
    if (!m_last_push) chk("store_accept_timeout", 32'd1, 32'd0);
    st_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    dm_stall = 1'b0;
    budget = 40;
    while (exp_q.size() > 0 && budget > 0) begin
      step();
      budget--;
    end
    if (exp_q.size() > 0) chk("drain_timeout", 32'd1, 32'd0);
    step();
  endtask

  initial begin
    int budget;
    int base;
    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    Reset = 1'b0;
    mon_en = 1'b1;
    step();
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_DMWr", DMWr, 1'b0);
    chk("rst_st_ready", st_ready, 1'b1);

    // Single word store, one-cycle latency to DM
    drive_store(32'h10, 32'hDEADBEEF, L_S_W, 32'h0040_0000);
    chk("sw_DMWr", DMWr, 1'b1);
    chk("sw_DMAddr", DMAddr, 32'h10);
    chk("sw_DIN", DIN, 32'hDEADBEEF);
    chk("sw_size", L_S_SL, L_S_W);
    step();
    chk("sw_empty_after", empty, 1'b1);

    // Fill under stall, fifth store held until space opens
    dm_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_store(32'(4 * i), 32'h1000 + 32'(i), L_S_W, 32'h0040_0100 + 32'(4 * i));
    end
    st_valid = 1'b1; st_addr = 32'h10; st_data = 32'h5555; st_size = L_S_H; st_pc = 32'h0040_0200;
    step();
    step();
    chk("fill_full", full, 1'b1);
    chk("fill_st_ready", st_ready, 1'b0);
    chk("fill_head", DMAddr, 32'h0);
    dm_stall = 1'b0;
    budget = 10;
    do begin
      step();
      budget--;
    end while (!m_last_push && budget > 0);
    chk("fifth_accepted", m_last_push, 1'b1);
    st_valid = 1'b0;
    drain();

    // Load conflict against a pending byte store
    dm_stall = 1'b1;
    drive_store(32'h23, 32'h0000_00AB, L_S_B, 32'h0040_0300);
    ld_req = 1'b1; ld_addr = 32'h20;
    #1;
    chk("ld_hit", ld_conflict, 1'b1);
    step();
    ld_addr = 32'h24;
    #1;
    chk("ld_miss", ld_conflict, 1'b0);
    step();
    drain();
    ld_addr = 32'h20;
    #1;
    chk("ld_after_drain", ld_conflict, 1'b0);
    step();
    ld_req = 1'b0;

    // Steady push+pop at count 2, pointers wrap
    dm_stall = 1'b1;
    drive_store(32'h100, 32'hA0, L_S_W, 32'h500);
    drive_store(32'h104, 32'hA1, L_S_W, 32'h504);
    dm_stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_store(32'h108 + 32'(4 * i), 32'hB0 + 32'(i), L_S_W, 32'h508 + 32'(4 * i));
      chk("steady_count2_ptr", (exp_q.size() == 2) && !empty && !full, 1'b1);
    end
    drain();

    // Reset with three entries and a store presented: nothing written
    dm_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_store(32'h200 + 32'(4 * i), 32'hC0 + 32'(i), L_S_W, 32'h600);
    end
    Reset = 1'b1; st_valid = 1'b1; st_addr = 32'h300;
    step();
    Reset = 1'b0; st_valid = 1'b0; dm_stall = 1'b0;
    #1;
    chk("rst3_empty", empty, 1'b1);
    chk("rst3_DMWr", DMWr, 1'b0);
    base = n_dm_writes;
    repeat (4) step();
    chk("rst3_no_writes", n_dm_writes, base);

    // Randomised traffic including odd size codes
    for (int c = 0; c < 300; c++) begin
      st_valid = ($urandom_range(0, 99) < 60);
      st_addr  = 32'($urandom_range(0, 15)) << 2 | 32'($urandom_range(0, 3));
      st_data  = $urandom;
      st_size  = 3'($urandom_range(0, 7));
      st_pc    = $urandom;
      dm_stall = ($urandom_range(0, 99) < 40);
      ld_req   = ($urandom_range(0, 1) == 1);
      ld_addr  = 32'($urandom_range(0, 15)) << 2 | 32'($urandom_range(0, 3));
      step();
    end
    st_valid = 1'b0; ld_req = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
